// File: rtl/seq_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seq_stream_ctrl
//   Word-level controller for an external bit-serial "1101" Mealy detector.
//   A word taken over the in_valid/in_ready handshake is shifted into the
//   detector MSB-first, one bit per clock. The detector is cleared for one
//   cycle before each word. Detector hits are counted, with saturation, and
//   the per-word count is returned over the out_valid/out_ready handshake.
//
//   Optional build macro: SEQ_HITMAP_EN adds out_hitmap. Bit WORD_W-1-i of
//   out_hitmap is set when the detector fired in shift cycle i.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   input word valid
//   in_data    input word, WORD_W bits, shifted MSB first
//   in_ready   controller can accept a word (IDLE only)
//   det_din    serial bit to detector din
//   det_rst    synchronous active-high reset to detector
//   det_y      detector Mealy output, sampled during SHIFT only
//   out_valid  result valid
//   out_count  hits seen in the last word, CNT_W bits, saturating
//   out_ready  consumer accepts result
//   busy       high in every state except IDLE
//   out_hitmap (SEQ_HITMAP_EN only) per-bit match positions
// -----------------------------------------------------------------------------
module seq_stream_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_din,
    output logic              det_rst,
    input  logic              det_y,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    input  logic              out_ready,
    output logic              busy
`ifdef SEQ_HITMAP_EN
    ,
    output logic [WORD_W-1:0] out_hitmap
`endif
);

    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_CLR    = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    // Saturating increment: the count sticks at its maximum instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = CNT_MAX;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    state_t              state_r, state_nxt_s;
    logic [WORD_W-1:0]   shreg_r, shreg_nxt_s;
    logic [IDX_W-1:0]    idx_r, idx_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0]    out_count_r, out_count_nxt_s;
    logic                in_ready_r, in_ready_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                det_rst_r, det_rst_nxt_s;
    logic                det_din_r, det_din_nxt_s;
    logic                out_valid_r, out_valid_nxt_s;
    logic                accept_s;

    assign accept_s  = (state_r == ST_IDLE) && in_valid && in_ready_r;

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign det_rst   = det_rst_r;
    assign det_din   = det_din_r;
    assign out_valid = out_valid_r;
    assign out_count = out_count_r;

    // Next-state, datapath and next-output logic. Outputs are decoded from
    // the next state so the registered outputs line up with the state.
    always_comb begin
        state_nxt_s     = state_r;
        shreg_nxt_s     = shreg_r;
        idx_nxt_s       = idx_r;
        cnt_nxt_s       = cnt_r;
        out_count_nxt_s = out_count_r;

        case (state_r)
            ST_INIT: begin
                state_nxt_s = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept_s) begin
                    shreg_nxt_s = in_data;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_CLR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLR: begin
                state_nxt_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                // det_y reflects the bit driven this cycle, so it is counted now.
                if (det_y) begin
                    cnt_nxt_s = sat_inc(cnt_r);
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                shreg_nxt_s = {shreg_r[WORD_W-2:0], 1'b0};
                idx_nxt_s   = idx_r + IDX_ONE;
                if (idx_r == IDX_LAST) begin
                    out_count_nxt_s = cnt_nxt_s;
                    state_nxt_s     = ST_REPORT;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_REPORT: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REPORT;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase

        in_ready_nxt_s  = 1'b0;
        busy_nxt_s      = 1'b1;
        det_rst_nxt_s   = 1'b0;
        det_din_nxt_s   = 1'b0;
        out_valid_nxt_s = 1'b0;

        case (state_nxt_s)
            ST_INIT: begin
                det_rst_nxt_s = 1'b1;
            end
            ST_IDLE: begin
                in_ready_nxt_s = 1'b1;
                busy_nxt_s     = 1'b0;
            end
            ST_CLR: begin
                det_rst_nxt_s = 1'b1;
            end
            ST_SHIFT: begin
                det_din_nxt_s = shreg_nxt_s[WORD_W-1];
            end
            ST_REPORT: begin
                out_valid_nxt_s = 1'b1;
            end
            default: begin
                det_rst_nxt_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_INIT;
            shreg_r     <= {WORD_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            out_count_r <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b1;
            det_rst_r   <= 1'b1;
            det_din_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            shreg_r     <= shreg_nxt_s;
            idx_r       <= idx_nxt_s;
            cnt_r       <= cnt_nxt_s;
            out_count_r <= out_count_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            busy_r      <= busy_nxt_s;
            det_rst_r   <= det_rst_nxt_s;
            det_din_r   <= det_din_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

`ifdef SEQ_HITMAP_EN
    logic [WORD_W-1:0] hitmap_r;

    assign out_hitmap = hitmap_r;

    // Match map: det_y shifted in from the LSB, so after WORD_W shifts the
    // first shift cycle lands on bit WORD_W-1, matching the in_data position.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hitmap_r <= {WORD_W{1'b0}};
        end else if (accept_s) begin
            hitmap_r <= {WORD_W{1'b0}};
        end else if (state_r == ST_SHIFT) begin
            hitmap_r <= {hitmap_r[WORD_W-2:0], det_y};
        end else begin
            hitmap_r <= hitmap_r;
        end
    end
`endif

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_stream_ctrl
//   Directed bench for seq_stream_ctrl. Two instances: default parameters
//   (WORD_W=8, CNT_W=4) and WORD_W=16, CNT_W=2 for saturation. Each instance
//   drives a behavioural "1101" overlapping Mealy detector modelled here.
// -----------------------------------------------------------------------------
module tb_seq_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst_s = 1'b0;

    logic        in_valid8_s = 1'b0;
    logic [7:0]  in_data8_s = 8'h00;
    logic        in_ready8_s, det_din8_s, det_rst8_s, det_y8_s;
    logic        out_valid8_s, busy8_s;
    logic [3:0]  out_count8_s;
    logic        out_ready8_s = 1'b1;

    logic        in_valid16_s = 1'b0;
    logic [15:0] in_data16_s = 16'h0000;
    logic        in_ready16_s, det_din16_s, det_rst16_s, det_y16_s;
    logic        out_valid16_s, busy16_s;
    logic [1:0]  out_count16_s;
    logic        out_ready16_s = 1'b1;

`ifdef SEQ_HITMAP_EN
    logic [7:0]  out_hitmap8_s;
    logic [15:0] out_hitmap16_s;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_stream_ctrl u_dut8 (
        .clk(clk), .rst(rst_s),
        .in_valid(in_valid8_s), .in_data(in_data8_s), .in_ready(in_ready8_s),
        .det_din(det_din8_s), .det_rst(det_rst8_s), .det_y(det_y8_s),
        .out_valid(out_valid8_s), .out_count(out_count8_s),
        .out_ready(out_ready8_s), .busy(busy8_s)
`ifdef SEQ_HITMAP_EN
        , .out_hitmap(out_hitmap8_s)
`endif
    );

    seq_stream_ctrl #(.WORD_W(16), .CNT_W(2)) u_dut16 (
        .clk(clk), .rst(rst_s),
        .in_valid(in_valid16_s), .in_data(in_data16_s), .in_ready(in_ready16_s),
        .det_din(det_din16_s), .det_rst(det_rst16_s), .det_y(det_y16_s),
        .out_valid(out_valid16_s), .out_count(out_count16_s),
        .out_ready(out_ready16_s), .busy(busy16_s)
`ifdef SEQ_HITMAP_EN
        , .out_hitmap(out_hitmap16_s)
`endif
    );

    // Detector model states: 0=none, 1="1", 2="11", 3="110".
    logic [1:0] d8_st = 2'd0;
    logic [1:0] d16_st = 2'd0;

    function automatic logic [1:0] det_next(input logic [1:0] st, input logic b);
        case (st)
            2'd0:    det_next = b ? 2'd1 : 2'd0;
            2'd1:    det_next = b ? 2'd2 : 2'd0;
            2'd2:    det_next = b ? 2'd2 : 2'd3;
            2'd3:    det_next = b ? 2'd1 : 2'd0;
            default: det_next = 2'd0;
        endcase
    endfunction

    assign det_y8_s  = (d8_st == 2'd3) && det_din8_s;
    assign det_y16_s = (d16_st == 2'd3) && det_din16_s;

    // Reference detector for the 8-bit instance.
    always @(posedge clk) begin
        if (det_rst8_s) d8_st <= 2'd0;
        else            d8_st <= det_next(d8_st, det_din8_s);
    end

    // Reference detector for the 16-bit instance.
    always @(posedge clk) begin
        if (det_rst16_s) d16_st <= 2'd0;
        else             d16_st <= det_next(d16_st, det_din16_s);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One word through the 8-bit instance; hold>0 keeps out_ready low that
    // many extra cycles in REPORT while offering a competing word.
    task automatic run_word8(input logic [7:0] data, input logic [3:0] exp_cnt,
                             input logic [7:0] exp_map, input int hold);
        chk("idle_in_ready", in_ready8_s, 1);
        chk("idle_busy", busy8_s, 0);
        in_data8_s   = data;
        in_valid8_s  = 1'b1;
        out_ready8_s = (hold == 0);
        step();
        in_valid8_s = 1'b0;
        chk("clr_det_rst", det_rst8_s, 1);
        chk("clr_in_ready", in_ready8_s, 0);
        chk("clr_det_din", det_din8_s, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("shift_det_din", det_din8_s, data[7-i]);
            chk("shift_det_rst", det_rst8_s, 0);
            chk("shift_no_valid", out_valid8_s, 0);
        end
        step();
        chk("rep_valid", out_valid8_s, 1);
        chk("rep_count", out_count8_s, exp_cnt);
        chk("rep_det_din", det_din8_s, 0);
`ifdef SEQ_HITMAP_EN
        chk("rep_hitmap", out_hitmap8_s, exp_map);
`else
        if (exp_map !== 8'hxx) begin
            chk("rep_busy", busy8_s, 1);
        end
`endif
        for (int h = 0; h < hold; h++) begin
            in_valid8_s = 1'b1;
            in_data8_s  = 8'hFF;
            step();
            chk("bp_valid", out_valid8_s, 1);
            chk("bp_count", out_count8_s, exp_cnt);
            chk("bp_in_ready", in_ready8_s, 0);
            chk("bp_busy", busy8_s, 1);
        end
        in_valid8_s  = 1'b0;
        out_ready8_s = 1'b1;
        step();
        chk("ret_valid_low", out_valid8_s, 0);
        chk("ret_in_ready", in_ready8_s, 1);
        chk("ret_busy", busy8_s, 0);
    endtask

    initial begin
        // Reset held for three cycles.
        rst_s = 1'b0;
        repeat (3) step();
        chk("rst_in_ready", in_ready8_s, 0);
        chk("rst_out_valid", out_valid8_s, 0);
        chk("rst_out_count", out_count8_s, 0);
        chk("rst_det_din", det_din8_s, 0);
        chk("rst_det_rst", det_rst8_s, 1);
        chk("rst_busy", busy8_s, 1);
        chk("rst16_in_ready", in_ready16_s, 0);
        rst_s = 1'b1;
        #1;
        chk("init_det_rst", det_rst8_s, 1);
        chk("init_in_ready", in_ready8_s, 0);
        step();
        chk("idle_det_rst", det_rst8_s, 0);
        chk("idle_in_ready0", in_ready8_s, 1);
        chk("idle_out_valid", out_valid8_s, 0);
        chk("idle_out_count", out_count8_s, 0);
        chk("idle_busy0", busy8_s, 0);
        chk("idle16_in_ready", in_ready16_s, 1);

        // Main function, back-to-back words, cross-word pattern.
        run_word8(8'hDA, 4'd2, 8'h12, 0);
        run_word8(8'h06, 4'd0, 8'h00, 0);
        run_word8(8'h80, 4'd0, 8'h00, 0);
        run_word8(8'h0D, 4'd1, 8'h01, 0);
        run_word8(8'hFF, 4'd0, 8'h00, 0);

        // Backpressure for five cycles.
        run_word8(8'hDD, 4'd2, 8'h11, 5);
        // The offered 8'hFF must not have been taken; a fresh word follows.
        run_word8(8'hDA, 4'd2, 8'h12, 0);

        // Saturation on the 16-bit / 2-bit-counter instance.
        in_data16_s  = 16'hDB6D;
        in_valid16_s = 1'b1;
        step();
        in_valid16_s = 1'b0;
        chk("w16_clr_det_rst", det_rst16_s, 1);
        for (int i = 0; i < 16; i++) begin
            step();
            chk("w16_det_din", det_din16_s, in_data16_s[15-i]);
            chk("w16_no_valid", out_valid16_s, 0);
        end
        step();
        chk("w16_valid", out_valid16_s, 1);
        chk("w16_count_sat", out_count16_s, 3);
`ifdef SEQ_HITMAP_EN
        chk("w16_hitmap", out_hitmap16_s, 16'h1249);
`endif
        step();
        chk("w16_ret_valid", out_valid16_s, 0);
        chk("w16_ret_busy", busy16_s, 0);

        // Reset in SHIFT cycle 4.
        in_data8_s  = 8'hDA;
        in_valid8_s = 1'b1;
        step();
        in_valid8_s = 1'b0;
        repeat (5) step();
        chk("mid_busy_pre", busy8_s, 1);
        rst_s = 1'b0;
        #1;
        chk("mid_in_ready", in_ready8_s, 0);
        chk("mid_out_valid", out_valid8_s, 0);
        chk("mid_out_count", out_count8_s, 0);
        chk("mid_det_din", det_din8_s, 0);
        chk("mid_det_rst", det_rst8_s, 1);
        chk("mid_busy", busy8_s, 1);
        repeat (2) step();
        rst_s = 1'b1;
        #1;
        chk("mid_init_det_rst", det_rst8_s, 1);
        step();
        chk("mid_idle_ready", in_ready8_s, 1);
        repeat (6) begin
            step();
            chk("mid_no_result", out_valid8_s, 0);
        end
        run_word8(8'h0D, 4'd1, 8'h01, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
